toggle_event_rx: RTL and testbench

//   Receive end of the toggle-signalling link: each level change on tgl_in
//   (driven by a toggle source, possibly from another clock domain or a pin)
//   is one event. Synchronises tgl_in, detects changes, emits a one-cycle

---
 rtl/toggle_event_rx.sv | 90 +++++++++
 tb/tb_toggle_event_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_rx.sv
// Toggle-link receiver: synchronises tgl_in, turns every level change into a
// one-cycle pulse and queues events in a saturating counter drained by valid/ready.
//
// state   | meaning
// INIT    | chain filling with the real tgl_in level; no events produced
// RUN     | change detection and event queueing active
module toggle_event_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgl_in,
  output logic             ev_pulse,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int INIT_W = $clog2(SYNC_STAGES + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]  PEND_MAX  = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                 state;
  logic [INIT_W-1:0]      init_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic                   sync_out;
  logic                   chg;
  logic                   dec;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign chg      = (state == ST_RUN) && (sync_out ^ prev);
  assign ev_valid = (pending != '0);
  assign dec      = ev_valid && ev_ready;

  // INIT holds one edge past the chain depth so prev samples a fully
  // refreshed sync_out; otherwise tgl_in=1 at release would look like a change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      sync_q   <= '0;
      prev     <= 1'b0;
      ev_pulse <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], tgl_in};
      ev_pulse <= chg;

      case (state)
        ST_INIT: begin
          if (init_cnt == INIT_LAST) begin
            prev  <= sync_out;
            state <= ST_RUN;
          end else begin
            init_cnt <= init_cnt + INIT_W'(1);
          end
        end
        ST_RUN: begin
          prev <= sync_out;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase

      if (chg && !dec) begin
        if (pending != PEND_MAX) begin
          pending <= pending + CNT_W'(1);
        end
      end else if (!chg && dec) begin
        pending <= pending - CNT_W'(1);
      end

      // a lost event wins over a same-cycle clear
      if (chg && !dec && (pending == PEND_MAX)) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Directed bench for toggle_event_rx: reset/INIT behaviour, latency,
// saturation and overflow, mid-run reset, and a randomised conservation run.
module tb_toggle_event_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tgl_in = 1'b0;
  logic       ev_pulse;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [3:0] pending;
  logic       overflow;
  logic       clr_ovf = 1'b0;

  int checks = 0;
  int failures = 0;

  toggle_event_rx #(.SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tgl_in   (tgl_in),
    .ev_pulse (ev_pulse),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .pending  (pending),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock edge; returns at the following negedge where outputs are stable
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int pulses;
  int sent, consumed, lost, gap;
  logic v_pre, r_pre;
  logic [3:0] p_pre;

  initial begin
    @(negedge clk);

    // 1: tgl_in high through reset release is not an event
    tgl_in = 1'b1;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pulses += int'(ev_pulse);
    end
    check("t1_pulses", pulses, 0);
    check("t1_pending", int'(pending), 0);
    check("t1_valid", int'(ev_valid), 0);

    // 2: single change latency and consume
    tgl_in = 1'b0;
    do_reset();
    repeat (5) tick();
    tgl_in = 1'b1;
    tick();
    check("t2_pulse_e0", int'(ev_pulse), 0);
    tick();
    check("t2_pulse_e1", int'(ev_pulse), 0);
    check("t2_valid_e1", int'(ev_valid), 0);
    tick();
    check("t2_pulse_e2", int'(ev_pulse), 1);
    check("t2_pending_e2", int'(pending), 1);
    check("t2_valid_e2", int'(ev_valid), 1);
    tick();
    check("t2_pulse_e3", int'(ev_pulse), 0);
    check("t2_pending_hold", int'(pending), 1);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("t2_pending_drained", int'(pending), 0);
    check("t2_valid_drained", int'(ev_valid), 0);

    // 3: saturate at 15, 16th change sets overflow, clr_ovf clears it
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tgl_in = ~tgl_in;
      repeat (3) begin
        tick();
        pulses += int'(ev_pulse);
      end
      if (i == 14) begin
        check("t3_pending_15th", int'(pending), 15);
        check("t3_ovf_15th", int'(overflow), 0);
      end
    end
    check("t3_pulses", pulses, 16);
    check("t3_pending_sat", int'(pending), 15);
    check("t3_ovf_set", int'(overflow), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t3_ovf_clr", int'(overflow), 0);
    check("t3_pending_after_clr", int'(pending), 15);

    // 4: change and consume in the same cycle at max
    tgl_in = ~tgl_in;
    tick();
    tick();
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("t4_pulse", int'(ev_pulse), 1);
    check("t4_pending", int'(pending), 15);
    check("t4_ovf", int'(overflow), 0);

    // 5: set overflow, drain to 5, then reset mid-burst
    tgl_in = ~tgl_in;
    repeat (3) tick();
    check("t5_ovf_pre", int'(overflow), 1);
    ev_ready = 1'b1;
    repeat (10) tick();
    ev_ready = 1'b0;
    check("t5_pending_5", int'(pending), 5);
    tgl_in = ~tgl_in;
    tick();
    rst_n = 1'b0;
    tick();
    check("t5_rst_pending", int'(pending), 0);
    check("t5_rst_ovf", int'(overflow), 0);
    check("t5_rst_pulse", int'(ev_pulse), 0);
    rst_n = 1'b1;
    tgl_in = ~tgl_in;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      pulses += int'(ev_pulse);
    end
    check("t5_init_pulses", pulses, 0);
    check("t5_init_pending", int'(pending), 0);
    tgl_in = ~tgl_in;
    repeat (3) tick();
    check("t5_run_again", int'(pending), 1);

    // 6: random spacing and ready; consumed + pending + lost == sent
    tgl_in = 1'b0;
    do_reset();
    repeat (5) tick();
    sent = 0; consumed = 0; lost = 0;
    gap = 2;
    for (int i = 0; i < 400; i++) begin
      if (i < 380) begin
        if (gap == 0) begin
          tgl_in = ~tgl_in;
          sent++;
          gap = int'($urandom_range(2, 5));
        end
        gap--;
      end
      ev_ready = ($urandom_range(0, 3) == 0);
      v_pre = ev_valid;
      r_pre = ev_ready;
      p_pre = pending;
      tick();
      if (v_pre && r_pre) consumed++;
      if (ev_pulse && !(v_pre && r_pre) && p_pre == 4'd15) lost++;
    end
    ev_ready = 1'b0;
    check("t6_conservation", consumed + int'(pending) + lost, sent);
    check("t6_ovf_iff_lost", int'(overflow), int'(lost > 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
